da_lut_loader: RTL and testbench

//  Upstream companion of fir_filter. Holds the 64 signed 16-bit FIR taps and, on start, computes
//  and streams the 2048-entry distributed-arithmetic LUT into the filter's CIN/CADDR/CLOAD port.
//  The output is one LUT entry per clock, 2048 consecutive cycles. This replaces bench-side

---
 rtl/da_lut_loader_pkg.sv | 24 ++
 rtl/da_lut_loader_if.sv | 25 ++
 rtl/da_lut_loader_da_group_sum.sv | 28 ++
 rtl/da_lut_loader.sv | 102 ++++++++++
 tb/tb_da_lut_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/da_lut_loader_pkg.sv
// Shared constants, types and FSM state encoding for the DA LUT loader.
package da_lut_loader_pkg;

  localparam int NTAPS     = 64;
  localparam int GRP       = 8;
  localparam int CW        = 16;
  localparam int LW        = 19;
  localparam int AW        = 11;
  localparam int LUT_DEPTH = 2048;
  localparam int TW        = 6;   // tap index width, log2(NTAPS)
  localparam int GB        = 3;   // tap-within-group index width, log2(GRP)

  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [LW-1:0] entry_t;
  typedef logic        [AW-1:0] addr_t;
  typedef logic        [TW-1:0] tap_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    DONE
  } state_t;

endpackage

// File: rtl/da_lut_loader_if.sv
// Host-side tap programming / start handshake plus the LUT load stream.
interface da_lut_loader_if;
  import da_lut_loader_pkg::*;

  logic     coef_wr;
  tap_idx_t coef_waddr;
  coef_t    coef_wdata;
  logic     start;
  logic     busy;
  logic     done;
  entry_t   cin;
  addr_t    caddr;
  logic     cload;

  modport master (
    output coef_wr, coef_waddr, coef_wdata, start,
    input  busy, done, cin, caddr, cload
  );

  modport slave (
    input  coef_wr, coef_waddr, coef_wdata, start,
    output busy, done, cin, caddr, cload
  );

endinterface

// File: rtl/da_lut_loader_da_group_sum.sv
// One DA LUT entry for a group: sum of the taps selected by the mask bits.
module da_group_sum
  import da_lut_loader_pkg::*;
(
  input  coef_t           taps [GRP],
  input  logic [GRP-1:0]  mask,
  output entry_t          sum
);

  entry_t lvl0 [GRP];
  entry_t lvl1 [GRP/2];
  entry_t lvl2 [GRP/4];

  // Masked sign-extension followed by a balanced three-level adder tree.
  always_comb begin
    for (int unsigned i = 0; i < GRP; i++) begin
      lvl0[i] = mask[i] ? entry_t'(taps[i]) : '0;
    end
    for (int unsigned i = 0; i < GRP/2; i++) begin
      lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
    end
    for (int unsigned i = 0; i < GRP/4; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
    sum = lvl2[0] + lvl2[1];
  end

endmodule

// File: rtl/da_lut_loader.sv
// Holds the FIR tap file and streams the 2048-entry DA LUT, one entry per clock.
module da_lut_loader
  import da_lut_loader_pkg::*;
(
  input  logic           clk_slow,
  input  logic           resetn,
  da_lut_loader_if.slave bus
);

  state_t state;
  state_t state_next;
  addr_t  cnt;
  coef_t  taps     [NTAPS];
  coef_t  grp_taps [GRP];
  entry_t entry;
  logic   busy;
  logic   build_en;
  logic   done_q;
  logic   cload_q;
  entry_t cin_q;
  addr_t  caddr_q;

  // Tap register file; writes are dropped while a build is in progress.
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        taps[i] <= '0;
      end
    end else if (bus.coef_wr && !busy) begin
      taps[bus.coef_waddr] <= bus.coef_wdata;
    end
  end

  // Select the 8 taps of the group addressed by the top counter bits.
  always_comb begin
    for (int unsigned b = 0; b < GRP; b++) begin
      grp_taps[b] = taps[{cnt[AW-1 -: GB], GB'(b)}];
    end
  end

  da_group_sum u_group_sum (
    .taps (grp_taps),
    .mask (cnt[GRP-1:0]),
    .sum  (entry)
  );

  // FSM state register.
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = BUILD;
      BUILD:   if (cnt == addr_t'(LUT_DEPTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy covers BUILD and the trailing DONE cycle.
  always_comb begin
    busy     = (state != IDLE);
    build_en = (state == BUILD);
  end

  // Entry counter; held at zero outside BUILD so every build starts at address 0.
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn)       cnt <= '0;
    else if (build_en) cnt <= cnt + 1'b1;
    else               cnt <= '0;
  end

  // Output register: one entry per BUILD edge; cin/caddr hold once cload drops.
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      cin_q   <= '0;
      caddr_q <= '0;
      cload_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (build_en) begin
        cin_q   <= entry;
        caddr_q <= cnt;
        cload_q <= 1'b1;
      end else begin
        cload_q <= 1'b0;
      end
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done_q;
  assign bus.cin   = cin_q;
  assign bus.caddr = caddr_q;
  assign bus.cload = cload_q;

endmodule

// File: tb/tb_da_lut_loader.sv
// Directed bench for da_lut_loader: framing, entry math, interlocks and resets.
module tb_da_lut_loader;
  import da_lut_loader_pkg::*;

  localparam int NS = 2053;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  always #5 clk = ~clk;

  da_lut_loader_if bus ();

  da_lut_loader dut (
    .clk_slow (clk),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int tap_m [NTAPS];

  logic        cl_s [NS];
  logic [10:0] ad_s [NS];
  logic [18:0] cv_s [NS];
  logic        bs_s [NS];
  logic        dn_s [NS];

  function automatic logic [18:0] model(input int a);
    int s;
    int g;
    s = 0;
    g = a >> 8;
    for (int b = 0; b < 8; b++) begin
      if (((a >> b) & 1) == 1) s += tap_m[8*g + b];
    end
    return 19'(s);
  endfunction

  // Number of framing violations in the captured stream (sample k = after edge E_k).
  function automatic int framing_errs();
    int n;
    n = 0;
    for (int k = 0; k < NS; k++) begin
      if (cl_s[k] !== ((k >= 1 && k <= 2048) ? 1'b1 : 1'b0)) n++;
      if (bs_s[k] !== ((k <= 2048) ? 1'b1 : 1'b0)) n++;
      if (dn_s[k] !== ((k == 2049) ? 1'b1 : 1'b0)) n++;
      if (k >= 1 && k <= 2048 && ad_s[k] !== 11'(k - 1)) n++;
    end
    if (ad_s[2049] !== 11'd2047) n++;
    return n;
  endfunction

  function automatic int entry_errs();
    int n;
    n = 0;
    for (int k = 1; k <= 2049; k++) begin
      if (cv_s[k] !== model((k <= 2048) ? k - 1 : 2047)) n++;
    end
    return n;
  endfunction

  task automatic write_tap(input int a, input int d);
    @(negedge clk);
    bus.coef_wr    = 1'b1;
    bus.coef_waddr = 6'(a);
    bus.coef_wdata = 16'(d);
    @(negedge clk);
    bus.coef_wr    = 1'b0;
    tap_m[a] = d;
  endtask

  // Pulse start and capture NS samples; optionally inject start+write at sample inj_at.
  task automatic run_stream(input int inj_at);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (k > 0) @(negedge clk);
      bus.start   = 1'b0;
      bus.coef_wr = 1'b0;
      cl_s[k] = bus.cload;
      ad_s[k] = bus.caddr;
      cv_s[k] = bus.cin;
      bs_s[k] = bus.busy;
      dn_s[k] = bus.done;
      if (k == inj_at) begin
        bus.start      = 1'b1;
        bus.coef_wr    = 1'b1;
        bus.coef_waddr = 6'd5;
        bus.coef_wdata = 16'd7;
      end
    end
  endtask

  task automatic test_reset;
    #1 resetn = 1'b0;
    #2;
    checks++; if (bus.cin !== 19'd0) begin failures++; $display("FAIL reset_cin got=%h exp=0", bus.cin); end
    checks++; if (bus.caddr !== 11'd0) begin failures++; $display("FAIL reset_caddr got=%h exp=0", bus.caddr); end
    checks++; if (bus.cload !== 1'b0) begin failures++; $display("FAIL reset_cload got=%b exp=0", bus.cload); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small_taps;
    int nz;
    write_tap(0, 100);
    write_tap(1, -3);
    run_stream(-1);
    checks++; if (cv_s[1] !== 19'd0) begin failures++; $display("FAIL small_a0 got=%h exp=00000", cv_s[1]); end
    checks++; if (cv_s[2] !== 19'd100) begin failures++; $display("FAIL small_a1 got=%h exp=00064", cv_s[2]); end
    checks++; if (cv_s[3] !== 19'h7FFFD) begin failures++; $display("FAIL small_a2 got=%h exp=7fffd", cv_s[3]); end
    checks++; if (cv_s[4] !== 19'd97) begin failures++; $display("FAIL small_a3 got=%h exp=00061", cv_s[4]); end
    nz = 0;
    for (int k = 257; k <= 2048; k++) if (cv_s[k] !== 19'd0) nz++;
    checks++; if (nz !== 0) begin failures++; $display("FAIL small_upper_zero nonzero=%0d exp=0", nz); end
    checks++; if (framing_errs() !== 0) begin failures++; $display("FAIL small_framing errs=%0d exp=0", framing_errs()); end
    checks++; if (entry_errs() !== 0) begin failures++; $display("FAIL small_entries errs=%0d exp=0", entry_errs()); end
  endtask

  task automatic test_extremes;
    for (int t = 56; t < 64; t++) write_tap(t, -32768);
    run_stream(-1);
    checks++; if (cv_s[2048] !== 19'h40000) begin failures++; $display("FAIL extreme_neg got=%h exp=40000", cv_s[2048]); end
    checks++; if (framing_errs() !== 0) begin failures++; $display("FAIL extreme_framing errs=%0d exp=0", framing_errs()); end
    for (int t = 56; t < 64; t++) write_tap(t, 32767);
    run_stream(-1);
    checks++; if (cv_s[2048] !== 19'h3FFF8) begin failures++; $display("FAIL extreme_pos got=%h exp=3fff8", cv_s[2048]); end
    checks++; if (cv_s[2049] !== 19'h3FFF8) begin failures++; $display("FAIL extreme_hold got=%h exp=3fff8", cv_s[2049]); end
    checks++; if (entry_errs() !== 0) begin failures++; $display("FAIL extreme_entries errs=%0d exp=0", entry_errs()); end
  endtask

  task automatic test_interlocks;
    write_tap(5, 1234);
    run_stream(1001);
    checks++; if (ad_s[1001] !== 11'd1000) begin failures++; $display("FAIL inter_inject_point got=%0d exp=1000", ad_s[1001]); end
    checks++; if (framing_errs() !== 0) begin failures++; $display("FAIL inter_framing errs=%0d exp=0", framing_errs()); end
    checks++; if (entry_errs() !== 0) begin failures++; $display("FAIL inter_entries errs=%0d exp=0", entry_errs()); end
    checks++; if (bs_s[2052] !== 1'b0) begin failures++; $display("FAIL inter_no_restart busy=%b exp=0", bs_s[2052]); end
    run_stream(-1);
    checks++; if (cv_s[33] !== 19'd1234) begin failures++; $display("FAIL inter_tap5_kept got=%0d exp=1234", cv_s[33]); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.coef_wr    = 1'b1;
    bus.coef_waddr = 6'd9;
    bus.coef_wdata = 16'd55;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.coef_wr = 1'b0;
    tap_m[9] = 55;
    repeat (2052) @(negedge clk);
    run_stream(-1);
    checks++; if (cv_s[259] !== 19'd55) begin failures++; $display("FAIL same_edge_write got=%0d exp=55", cv_s[259]); end
    checks++; if (entry_errs() !== 0) begin failures++; $display("FAIL same_edge_entries errs=%0d exp=0", entry_errs()); end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (1001) @(negedge clk);
    checks++; if (bus.caddr !== 11'd1000) begin failures++; $display("FAIL mid_point got=%0d exp=1000", bus.caddr); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus.cin !== 19'd0) begin failures++; $display("FAIL mid_reset_cin got=%h exp=0", bus.cin); end
    checks++; if (bus.caddr !== 11'd0) begin failures++; $display("FAIL mid_reset_caddr got=%h exp=0", bus.caddr); end
    checks++; if (bus.cload !== 1'b0) begin failures++; $display("FAIL mid_reset_cload got=%b exp=0", bus.cload); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mid_reset_done got=%b exp=0", bus.done); end
    @(negedge clk);
    resetn = 1'b1;
    for (int t = 0; t < NTAPS; t++) tap_m[t] = 0;
    write_tap(3, -7);
    run_stream(-1);
    checks++; if (framing_errs() !== 0) begin failures++; $display("FAIL mid_restart_framing errs=%0d exp=0", framing_errs()); end
    checks++; if (cv_s[9] !== 19'h7FFF9) begin failures++; $display("FAIL mid_restart_tap3 got=%h exp=7fff9", cv_s[9]); end
    checks++; if (entry_errs() !== 0) begin failures++; $display("FAIL mid_restart_entries errs=%0d exp=0", entry_errs()); end
  endtask

  task automatic test_random;
    for (int t = 0; t < NTAPS; t++) write_tap(t, int'($signed(16'($urandom))));
    run_stream(-1);
    checks++; if (framing_errs() !== 0) begin failures++; $display("FAIL random_framing errs=%0d exp=0", framing_errs()); end
    checks++; if (entry_errs() !== 0) begin failures++; $display("FAIL random_entries errs=%0d exp=0", entry_errs()); end
  endtask

  initial begin
    bus.coef_wr    = 1'b0;
    bus.coef_waddr = '0;
    bus.coef_wdata = '0;
    bus.start      = 1'b0;
    for (int t = 0; t < NTAPS; t++) tap_m[t] = 0;
    test_reset;
    test_small_taps;
    test_extremes;
    test_interlocks;
    test_back_to_back;
    test_reset_midstream;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
